// File: rtl/fb_load_sequencer.sv
// Framebuffer reload sequencer: debounces the mode switches, blanks the display,
// clears the framebuffer, then lets the ROM->RAM copier run until done or timeout.
module fb_load_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FB_DEPTH        = 307200,
    parameter int TIMEOUT_CYCLES  = 4194304,
    parameter int ADDR_W          = 19,
    parameter int DATA_W          = 8,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        sw,
    output logic              cp_start,
    input  logic              cp_done,
    input  logic [ADDR_W-1:0] cp_wraddr,
    input  logic [DATA_W-1:0] cp_data,
    input  logic              cp_wren,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic [3:0]        mode,
    output logic              display_enable,
    output logic              busy,
    output logic              fault,
    output logic [2:0]        fsm_state
);

    localparam logic [2:0] SETTLE = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] COPY   = 3'd3;
    localparam logic [2:0] SHOW   = 3'd4;
    localparam logic [2:0] FAULT  = 3'd5;

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [2:0]        state;
    logic              first_load;
    logic [3:0]        candidate;
    logic [DB_W-1:0]   db_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_wren;
    logic              stable;
    logic              reload_req;
    logic              done_ok;

    assign fsm_state  = state;
    assign stable     = (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign reload_req = stable && (first_load || (candidate != mode));
    // The copier may still show done from its previous run for two cycles after a start.
    assign done_ok    = cp_done && (to_cnt >= TO_W'(2));
    assign cp_start   = (state == START);

    always_ff @(posedge clk) begin
        if (reset) begin
            candidate <= sw;
            db_cnt    <= '0;
        end else if (sw != candidate) begin
            candidate <= sw;
            db_cnt    <= '0;
        end else if (!stable) begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= SETTLE;
            mode           <= 4'd0;
            display_enable <= 1'b0;
            busy           <= 1'b0;
            fault          <= 1'b0;
            first_load     <= 1'b1;
            clr_addr       <= '0;
            clr_wren       <= 1'b0;
            to_cnt         <= '0;
        end else begin
            case (state)
                SETTLE, SHOW, FAULT: begin
                    if (reload_req) begin
                        state          <= CLEAR;
                        display_enable <= 1'b0;
                        busy           <= 1'b1;
                        fault          <= 1'b0;
                        clr_addr       <= '0;
                        clr_wren       <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_addr == ADDR_W'(FB_DEPTH - 1)) begin
                        state    <= START;
                        clr_wren <= 1'b0;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + ADDR_W'(1);
                    end
                end
                START: begin
                    mode       <= candidate;
                    first_load <= 1'b0;
                    to_cnt     <= '0;
                    state      <= COPY;
                end
                COPY: begin
                    // Done takes priority over a timeout landing in the same cycle.
                    if (done_ok) begin
                        state          <= SHOW;
                        display_enable <= 1'b1;
                        busy           <= 1'b0;
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state <= FAULT;
                        fault <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: state <= SETTLE;
            endcase
        end
    end

    always_comb begin
        ram_wraddr = clr_addr;
        ram_data   = clr_wren ? CLEAR_COLOR : '0;
        ram_wren   = clr_wren;
        if (state == COPY) begin
            ram_wraddr = cp_wraddr;
            ram_data   = cp_data;
            ram_wren   = cp_wren;
        end
    end

endmodule

// File: tb/tb_fb_load_sequencer.sv
// Directed bench for fb_load_sequencer: write-port and start/mode scoreboards
// plus per-step checks of the control outputs.
module tb_fb_load_sequencer;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int W      = ADDR_W + DATA_W;

    localparam logic [2:0] S_SETTLE = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_COPY   = 3'd3;
    localparam logic [2:0] S_SHOW   = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        sw = 4'd0;
    logic              cp_start;
    logic              cp_done = 1'b0;
    logic [ADDR_W-1:0] cp_wraddr = '0;
    logic [DATA_W-1:0] cp_data = '0;
    logic              cp_wren = 1'b0;
    logic [ADDR_W-1:0] ram_wraddr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [3:0]        mode;
    logic              display_enable;
    logic              busy;
    logic              fault;
    logic [2:0]        fsm_state;

    logic [W-1:0] exp_q[$];
    logic [3:0]   exp_mode_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    logic mode_pending = 1'b0;

    fb_load_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .FB_DEPTH(16),
        .TIMEOUT_CYCLES(64),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CLEAR_COLOR(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw(sw),
        .cp_start(cp_start),
        .cp_done(cp_done),
        .cp_wraddr(cp_wraddr),
        .cp_data(cp_data),
        .cp_wren(cp_wren),
        .ram_wraddr(ram_wraddr),
        .ram_data(ram_data),
        .ram_wren(ram_wren),
        .mode(mode),
        .display_enable(display_enable),
        .busy(busy),
        .fault(fault),
        .fsm_state(fsm_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "bench did not finish");
    end

    // Monitor: every write-port beat and every start pulse is matched against the queues
    always @(negedge clk) begin
        if (mode_pending) begin
            mode_pending = 1'b0;
            n_cmp++;
            if (exp_mode_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_cp_start: actual mode %0h required no start", mode);
            end else begin
                logic [3:0] em;
                em = exp_mode_q.pop_front();
                if (mode !== em) begin
                    n_fail++;
                    $display("FAIL mode_after_start: actual %0h required %0h", mode, em);
                end
            end
        end
        if (cp_start === 1'b1) mode_pending = 1'b1;
        if (ram_wren === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: actual addr %0h data %0h required none", ram_wraddr, ram_data);
            end else begin
                logic [W-1:0] ew;
                ew = exp_q.pop_front();
                if ({ram_wraddr, ram_data} !== ew) begin
                    n_fail++;
                    $display("FAIL ram_write: actual %0h/%0h required %0h/%0h",
                             ram_wraddr, ram_data, ew[W-1:DATA_W], ew[DATA_W-1:0]);
                end
            end
        end
    end

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_clear(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({ADDR_W'(i), 8'h00});
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, output int cycles);
        cycles = 0;
        while (fsm_state !== target && cycles < budget) begin
            cyc();
            cycles++;
        end
        if (fsm_state !== target) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_state: actual state %0d required %0d", fsm_state, target);
        end
    endtask

    task automatic wait_addr(input logic [ADDR_W-1:0] a, input int budget, output int cycles);
        cycles = 0;
        while (ram_wraddr !== a && cycles < budget) begin
            cyc();
            cycles++;
        end
    endtask

    task automatic check_reset_values();
        check("rst_state", fsm_state, S_SETTLE);
        check("rst_mode", mode, 0);
        check("rst_display_enable", display_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_ram_wren", ram_wren, 0);
        check("rst_ram_wraddr", ram_wraddr, 0);
        check("rst_ram_data", ram_data, 0);
        check("rst_cp_start", cp_start, 0);
    endtask

    initial begin
        int n;

        // Cold load
        sw = 4'd2;
        reset = 1'b1;
        repeat (3) cyc();
        check_reset_values();
        push_clear(16);
        exp_mode_q.push_back(4'd2);
        reset = 1'b0;
        repeat (3) cyc();
        check("cold_still_settle", fsm_state, S_SETTLE);
        cyc();
        check("cold_enter_clear", fsm_state, S_CLEAR);
        check("cold_busy", busy, 1);
        wait_state(S_START, 20, n);
        check("cold_clear_cycles", n, 16);
        check("cold_cp_start", cp_start, 1);
        cyc();
        check("cold_copy", fsm_state, S_COPY);
        check("cold_cp_start_low", cp_start, 0);

        // Passthrough while copying
        exp_q.push_back({ADDR_W'(5), 8'hA5});
        cp_wraddr = ADDR_W'(5);
        cp_data = 8'hA5;
        cp_wren = 1'b1;
        #1;
        check("pass_addr", ram_wraddr, 5);
        check("pass_data", ram_data, 8'hA5);
        check("pass_wren", ram_wren, 1);
        cyc();
        cp_wren = 1'b0;
        repeat (7) cyc();
        check("cold_wait_done", fsm_state, S_COPY);
        cp_done = 1'b1;
        cyc();
        check("cold_show", fsm_state, S_SHOW);
        check("cold_display_enable", display_enable, 1);
        check("cold_busy_low", busy, 0);
        cp_done = 1'b0;
        cp_wren = 1'b1;
        cp_wraddr = ADDR_W'(3);
        #1;
        check("show_wren_blocked", ram_wren, 0);
        cyc();
        cp_wren = 1'b0;

        // Bounce 2->3->2->3 then hold 3; stale done held throughout the copy
        sw = 4'd3;
        repeat (2) begin cyc(); check("bounce_hold_show", fsm_state, S_SHOW); end
        sw = 4'd2;
        repeat (2) begin cyc(); check("bounce_hold_show", fsm_state, S_SHOW); end
        sw = 4'd3;
        push_clear(16);
        exp_mode_q.push_back(4'd3);
        wait_state(S_CLEAR, 10, n);
        check("bounce_debounce_cycles", n, 5);
        check("bounce_display_off", display_enable, 0);
        cp_done = 1'b1;
        wait_state(S_START, 20, n);
        cyc();
        check("stale_copy_entry", fsm_state, S_COPY);
        wait_state(S_SHOW, 10, n);
        check("stale_done_copy_cycles", n, 3);
        cp_done = 1'b0;
        sw = 4'd2;
        cyc();
        sw = 4'd3;
        repeat (10) begin cyc(); check("glitch_no_reload", fsm_state, S_SHOW); end

        // Timeout to fault, then recovery with a mid-clear switch change
        sw = 4'd4;
        push_clear(16);
        exp_mode_q.push_back(4'd4);
        wait_state(S_CLEAR, 10, n);
        wait_state(S_START, 20, n);
        cyc();
        wait_state(S_FAULT, 80, n);
        check("timeout_cycles", n, 64);
        check("fault_set", fault, 1);
        check("fault_display_off", display_enable, 0);
        check("fault_busy_low", busy, 0);
        repeat (8) cyc();
        check("fault_no_retrigger", fsm_state, S_FAULT);
        sw = 4'd5;
        push_clear(16);
        exp_mode_q.push_back(4'd6);
        wait_state(S_CLEAR, 10, n);
        check("fault_cleared", fault, 0);
        wait_addr(ADDR_W'(7), 20, n);
        check("midclear_reach_addr7", n, 7);
        sw = 4'd6;
        wait_state(S_START, 20, n);
        check("midclear_remaining_cycles", n, 9);
        cyc();
        cp_done = 1'b1;
        wait_state(S_SHOW, 10, n);
        cp_done = 1'b0;
        check("midclear_mode", mode, 6);
        repeat (8) begin cyc(); check("midclear_no_second_reload", fsm_state, S_SHOW); end

        // Reset at clear address 9
        sw = 4'd7;
        push_clear(10);
        wait_state(S_CLEAR, 10, n);
        wait_addr(ADDR_W'(9), 20, n);
        check("rstmid_reach_addr9", n, 9);
        reset = 1'b1;
        cyc();
        check_reset_values();
        reset = 1'b0;
        push_clear(16);
        exp_mode_q.push_back(4'd7);
        wait_state(S_CLEAR, 10, n);
        check("rstmid_debounce_cycles", n, 4);
        wait_state(S_START, 20, n);
        check("rstmid_clear_cycles", n, 16);
        cyc();
        cp_done = 1'b1;
        wait_state(S_SHOW, 10, n);
        cp_done = 1'b0;
        check("rstmid_display_enable", display_enable, 1);
        repeat (3) cyc();

        check("write_queue_drained", exp_q.size(), 0);
        check("mode_queue_drained", exp_mode_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
